// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory access unit.
// Beat geometry assumes the default 32-bit word and 256-bit vector.
package mem_pkg;

  localparam int N_DEF      = 32;
  localparam int V_DEF      = 256;
  localparam int NBEATS     = V_DEF / N_DEF;
  localparam int WORD_BYTES = N_DEF / 8;

  typedef enum logic [2:0] {
    IDLE,
    VWR,
    VRD,
    VDRAIN,
    VDONE
  } mau_state_e;

endpackage

// File: rtl/memory_access_unit_buffer.sv
// Eight-word register file for vector beats.
// Supports parallel load, single-word indexed write and parallel read.
import mem_pkg::*;

module vector_beat_buffer #(
  parameter int W  = 32,
  parameter int NB = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [W*NB-1:0]       load_data_i,
  input  logic                  wr_i,
  input  logic [$clog2(NB)-1:0] wr_idx_i,
  input  logic [W-1:0]          wr_data_i,
  output logic [W*NB-1:0]       data_o
);

  logic [NB-1:0][W-1:0] mem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else if (load_i) begin
      mem_q <= load_data_i;
    end else if (wr_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign data_o = mem_q;

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage access unit: scalar pass-through plus
// eight-beat vector store/load bursts over the scalar bus.
import mem_pkg::*;

module memory_access_unit #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           MemWriteM,
  input  logic           MemReadM,
  input  logic           VecDataM,
  input  logic [N-1:0]   AddressM,
  input  logic [N/8-1:0] ByteenaM,
  input  logic [N-1:0]   WriteDataM,
  input  logic [V-1:0]   WriteDataVM,
  input  logic [N-1:0]   ReadData,
  output logic [N-1:0]   AddressData,
  output logic [N/8-1:0] ByteenaData,
  output logic [N-1:0]   WriteData,
  output logic           RdenData,
  output logic           WrenData,
  output logic [N-1:0]   ReadDataM,
  output logic [V-1:0]   ReadDataVM,
  output logic           DoneVM,
  output logic           Busy
);

  localparam int NB = V / N;
  localparam logic [2:0] KLAST = 3'(NBEATS - 1);

  mau_state_e state_q, state_d;
  logic [2:0]   k_q, k_d;
  logic [N-1:0] base_q, base_d;
  logic         rd_pend_q;
  logic [2:0]   rd_idx_q;

  logic         wren, rden, wload;
  logic [N-1:0] beat_addr;
  logic [NB-1:0][N-1:0] wwords;

  assign beat_addr = base_q + {{(N-5){1'b0}}, k_q, 2'b00};
  assign ReadDataM = ReadData;
  assign WrenData  = en & wren;
  assign RdenData  = en & rden;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    base_d      = base_q;
    wload       = 1'b0;
    wren        = 1'b0;
    rden        = 1'b0;
    Busy        = 1'b0;
    DoneVM      = 1'b0;
    AddressData = AddressM;
    ByteenaData = ByteenaM;
    WriteData   = WriteDataM;
    unique case (state_q)
      IDLE: begin
        if (VecDataM & (MemWriteM | MemReadM)) begin
          Busy    = 1'b1;
          wload   = 1'b1;
          base_d  = {AddressM[N-1:2], 2'b00};
          k_d     = 3'd0;
          state_d = MemWriteM ? VWR : VRD;
        end else begin
          wren = MemWriteM;
          rden = MemReadM & ~MemWriteM;
        end
      end
      VWR: begin
        wren        = 1'b1;
        ByteenaData = '1;
        AddressData = beat_addr;
        WriteData   = wwords[k_q];
        Busy        = (k_q != KLAST);
        k_d         = k_q + 3'd1;
        if (k_q == KLAST) state_d = IDLE;
      end
      VRD: begin
        rden        = 1'b1;
        ByteenaData = '1;
        AddressData = beat_addr;
        WriteData   = '0;
        Busy        = 1'b1;
        k_d         = k_q + 3'd1;
        if (k_q == KLAST) state_d = VDRAIN;
      end
      VDRAIN: begin
        AddressData = base_q;
        ByteenaData = '0;
        WriteData   = '0;
        Busy        = 1'b1;
        state_d     = VDONE;
      end
      VDONE: begin
        AddressData = base_q;
        ByteenaData = '0;
        WriteData   = '0;
        DoneVM      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      base_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
    end
  end

  // Returning load words are captured even while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_idx_q  <= 3'd0;
    end else begin
      rd_pend_q <= RdenData & (state_q == VRD);
      rd_idx_q  <= k_q;
    end
  end

  vector_beat_buffer #(.W(N), .NB(NB)) u_wbuf (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (wload & en),
    .load_data_i (WriteDataVM),
    .wr_i        (1'b0),
    .wr_idx_i    (3'd0),
    .wr_data_i   ({N{1'b0}}),
    .data_o      (wwords)
  );

  vector_beat_buffer #(.W(N), .NB(NB)) u_rbuf (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (1'b0),
    .load_data_i ({V{1'b0}}),
    .wr_i        (rd_pend_q),
    .wr_idx_i    (rd_idx_q),
    .wr_data_i   (ReadData),
    .data_o      (ReadDataVM)
  );

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: scalar table plus
// hand-written vector burst, wrap, enable and reset sequences.
module tb_memory_access_unit;

  logic         clk = 1'b0;
  logic         rst, en;
  logic         mw, mr, vd;
  logic [31:0]  addr;
  logic [3:0]   be;
  logic [31:0]  wd;
  logic [255:0] wdv;
  logic [31:0]  rdata;
  logic [31:0]  AddressData, WriteData, ReadDataM;
  logic [3:0]   ByteenaData;
  logic         RdenData, WrenData, DoneVM, Busy;
  logic [255:0] ReadDataVM;

  int checks = 0;
  int errors = 0;

  memory_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .MemWriteM   (mw),
    .MemReadM    (mr),
    .VecDataM    (vd),
    .AddressM    (addr),
    .ByteenaM    (be),
    .WriteDataM  (wd),
    .WriteDataVM (wdv),
    .ReadData    (rdata),
    .AddressData (AddressData),
    .ByteenaData (ByteenaData),
    .WriteData   (WriteData),
    .RdenData    (RdenData),
    .WrenData    (WrenData),
    .ReadDataM   (ReadDataM),
    .ReadDataVM  (ReadDataVM),
    .DoneVM      (DoneVM),
    .Busy        (Busy)
  );

  always #5 clk = ~clk;

  // Memory model: word at address A reads back as A.
  always @(posedge clk)
    rdata <= RdenData ? AddressData : 32'hDEAD0000;

  task automatic chk1(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chk32(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chkv(string nm, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    mw = 1'b0; mr = 1'b0; vd = 1'b0;
    addr = 32'h0; be = 4'h0; wd = 32'h0;
  endtask

  task automatic junk_in();
    mw = 1'b1; mr = 1'b1; vd = 1'b1;
    addr = 32'hBAD0; be = 4'h5; wd = 32'h55;
    wdv = '1;
  endtask

  // Vector load from address a; expected words are base+4j.
  task automatic vload(input logic [31:0] a, input logic [31:0] base);
    logic [255:0] ev;
    for (int j = 0; j < 8; j++) ev[j*32 +: 32] = base + 32'(4*j);
    nxt();
    vd = 1'b1; mr = 1'b1; mw = 1'b0; addr = a;
    smp();
    chk1("vld req busy", Busy, 1'b1);
    chk1("vld req rden", RdenData, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      nxt();
      if (c < 10) junk_in(); else idle_in();
      smp();
      if (c <= 8) begin
        chk1("vld rden", RdenData, 1'b1);
        chk1("vld wren", WrenData, 1'b0);
        chk32("vld addr", AddressData, base + 32'(4*(c-1)));
        chk1("vld busy", Busy, 1'b1);
      end else if (c == 9) begin
        chk1("vld drain rden", RdenData, 1'b0);
        chk1("vld drain busy", Busy, 1'b1);
        chk1("vld drain done", DoneVM, 1'b0);
      end else begin
        chk1("vld done", DoneVM, 1'b1);
        chk1("vld done busy", Busy, 1'b0);
        chkv("vld data", ReadDataVM, ev);
      end
    end
    nxt();
    smp();
    chk1("vld done pulse", DoneVM, 1'b0);
    chkv("vld hold", ReadDataVM, ev);
  endtask

  typedef struct {
    logic        en, mw, mr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_wren, e_rden;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [255:0] ev;
    int cyc, nwr;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h40, 4'h3, 32'hDEADBEEF,
               32'h40, 4'h3, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h84, 4'hF, 32'h0,
               32'h84, 4'hF, 32'h0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h13, 4'h8, 32'h12345678,
               32'h13, 4'h8, 32'h12345678, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hA0, 4'h1, 32'h1,
               32'hA0, 4'h1, 32'h1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h44, 4'hF, 32'hCAFE,
               32'h44, 4'hF, 32'hCAFE, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b1; wdv = '0;
    idle_in();
    repeat (2) @(posedge clk);
    smp();
    chk1("rst done", DoneVM, 1'b0);
    chk1("rst busy", Busy, 1'b0);
    chkv("rst rdvm", ReadDataVM, 256'h0);
    nxt();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      nxt();
      en = tbl[i].en; mw = tbl[i].mw; mr = tbl[i].mr; vd = 1'b0;
      addr = tbl[i].addr; be = tbl[i].be; wd = tbl[i].wd;
      smp();
      chk32("scl addr", AddressData, tbl[i].e_addr);
      chk32("scl be", {28'h0, ByteenaData}, {28'h0, tbl[i].e_be});
      chk32("scl wd", WriteData, tbl[i].e_wd);
      chk1("scl wren", WrenData, tbl[i].e_wren);
      chk1("scl rden", RdenData, tbl[i].e_rden);
      chk1("scl busy", Busy, 1'b0);
    end
    nxt();
    en = 1'b1;
    idle_in();

    // Vector store at 0x100, words 1..8, inputs scrambled after request.
    nxt();
    vd = 1'b1; mw = 1'b1; mr = 1'b0; addr = 32'h100;
    for (int j = 0; j < 8; j++) wdv[j*32 +: 32] = 32'(j+1);
    smp();
    chk1("vst req busy", Busy, 1'b1);
    chk1("vst req wren", WrenData, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      nxt();
      if (c < 8) junk_in(); else idle_in();
      smp();
      chk1("vst wren", WrenData, 1'b1);
      chk1("vst rden", RdenData, 1'b0);
      chk32("vst addr", AddressData, 32'h100 + 32'(4*(c-1)));
      chk32("vst data", WriteData, 32'(c));
      chk32("vst be", {28'h0, ByteenaData}, 32'hF);
      chk1("vst busy", Busy, c < 8);
    end
    nxt();
    smp();
    chk1("vst end busy", Busy, 1'b0);
    chk1("vst end wren", WrenData, 1'b0);

    vload(32'h103, 32'h100);

    // Write+read+vector: write path only; load data must persist.
    for (int j = 0; j < 8; j++) ev[j*32 +: 32] = 32'h100 + 32'(4*j);
    nxt();
    vd = 1'b1; mw = 1'b1; mr = 1'b1; addr = 32'h200;
    nwr = 0;
    for (int c = 0; c <= 9; c++) begin
      smp();
      chk1("both rden", RdenData, 1'b0);
      if (WrenData) nwr++;
      nxt();
      idle_in();
    end
    chk32("both writes", 32'(nwr), 32'd8);
    chkv("both rdvm hold", ReadDataVM, ev);

    vload(32'hFFFFFFF0, 32'hFFFFFFF0);

    // Enable low for two cycles mid-load; returning word still captured.
    for (int j = 0; j < 8; j++) ev[j*32 +: 32] = 32'h300 + 32'(4*j);
    nxt();
    vd = 1'b1; mr = 1'b1; mw = 1'b0; addr = 32'h300;
    cyc = 0;
    while (cyc < 20) begin
      nxt();
      cyc++;
      idle_in();
      en = !(cyc == 3 || cyc == 4);
      smp();
      if (cyc == 3) begin
        chk1("en0 rden", RdenData, 1'b0);
        chk32("en0 addr", AddressData, 32'h308);
      end
      if (DoneVM) break;
    end
    en = 1'b1;
    chk32("en0 done cycle", 32'(cyc), 32'd12);
    chkv("en0 data", ReadDataVM, ev);

    // Reset during the k=3 write beat.
    nxt();
    vd = 1'b1; mw = 1'b1; mr = 1'b0; addr = 32'h400;
    nwr = 0;
    for (int c = 1; c <= 6; c++) begin
      nxt();
      idle_in();
      if (c == 4) rst = 1'b1;
      if (c == 5) rst = 1'b0;
      smp();
      if (WrenData) nwr++;
      if (c == 4) begin
        chk1("rst mid busy", Busy, 1'b0);
        chk1("rst mid wren", WrenData, 1'b0);
      end
    end
    chk32("rst mid writes", 32'(nwr), 32'd3);
    chkv("rst mid rdvm", ReadDataVM, 256'h0);
    nxt();
    mw = 1'b1; addr = 32'h44; be = 4'hF; wd = 32'h77;
    smp();
    chk1("post rst wren", WrenData, 1'b1);
    chk32("post rst addr", AddressData, 32'h44);
    chk1("post rst busy", Busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
